stage_fifo_sync: RTL and testbench

- Parametrised, single-clock successor to the three-stage req/ack micropipeline.
- Keeps the same req/ack/data port naming on both sides, replaces the fixed 3-deep asynchronous stage chain with a DEPTH-deep circular buffer, and adds occupancy reporting, an almost-full flag and a synchronous flush.
- Sits between a producer that drives req_in/data_in and a consumer that drives ack_in.

---
 rtl/stage_fifo_sync.sv | 116 +++++++++++
 tb/tb_stage_fifo_sync.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_fifo_sync.sv
// ============================================================================
// Module      : stage_fifo_sync
// Description : Single-clock req/ack FIFO with DEPTH-deep circular buffer,
//               level/almost_full reporting and synchronous flush.
//               Optional macro STAGE_FIFO_BYPASS_EN adds empty-FIFO bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module stage_fifo_sync #(
    parameter int DATA_WITH = 3,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_in,
    input  logic [DATA_WITH-1:0] data_in,
    output logic                 ack_out,
    output logic                 req_out,
    output logic [DATA_WITH-1:0] data_out,
    input  logic                 ack_in,
    input  logic                 flush,
    output logic [LVL_W-1:0]     level,
    output logic                 almost_full
);

    localparam int                 c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(DEPTH - 1);
    localparam logic [LVL_W-1:0]   c_lvl_full  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]   c_lvl_afull = LVL_W'(AFULL_LVL);
    localparam logic [LVL_W-1:0]   c_lvl_one   = LVL_W'(1);

    logic [DATA_WITH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 r_almost_full;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_ack_out;
    logic                 w_req_out;
    logic [DATA_WITH-1:0] w_data_out;
    logic [LVL_W-1:0]     w_level_nxt;
`ifdef STAGE_FIFO_BYPASS_EN
    logic                 w_bypass;
`endif

    always_comb begin
        w_full    = (r_level == c_lvl_full);
        w_empty   = (r_level == '0);
        w_ack_out = !w_full && !rst && !flush;
`ifdef STAGE_FIFO_BYPASS_EN
        // An empty FIFO presents the producer's word directly; it is only
        // stored when the consumer does not take it in the same cycle.
        w_bypass   = w_empty && !flush && !rst;
        w_req_out  = w_bypass ? req_in : (!w_empty && !flush);
        w_data_out = w_bypass ? data_in : (w_empty ? '0 : r_mem[r_rd_ptr]);
        w_rd       = w_req_out && ack_in && !w_empty;
        w_wr       = req_in && w_ack_out && !(w_bypass && ack_in);
`else
        w_req_out  = !w_empty && !flush;
        w_data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        w_rd       = w_req_out && ack_in;
        w_wr       = req_in && w_ack_out;
`endif
    end

    always_comb begin
        w_level_nxt = r_level;
        if (rst || flush) begin
            w_level_nxt = '0;
        end else if (w_wr && !w_rd) begin
            w_level_nxt = r_level + c_lvl_one;
        end else if (w_rd && !w_wr) begin
            w_level_nxt = r_level - c_lvl_one;
        end
    end

    // Explicit wrap keeps non-power-of-two depths correct.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
        end
        r_level       <= w_level_nxt;
        r_almost_full <= (w_level_nxt >= c_lvl_afull);
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign ack_out     = w_ack_out;
    assign req_out     = w_req_out;
    assign data_out    = w_data_out;
    assign level       = r_level;
    assign almost_full = r_almost_full;

endmodule

`default_nettype wire

// File: tb/tb_stage_fifo_sync.sv
// ============================================================================
// Module      : tb_stage_fifo_sync
// Description : Self-checking bench for stage_fifo_sync (DEPTH=4 and DEPTH=3
//               instances) against a queue model; honours STAGE_FIFO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stage_fifo_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_req, a_ack, a_flush;
    logic [2:0] a_din;
    logic       a_ack_out, a_req_out, a_afull;
    logic [2:0] a_dout;
    logic [2:0] a_level;

    logic       b_req, b_ack, b_flush;
    logic [2:0] b_din;
    logic       b_ack_out, b_req_out, b_afull;
    logic [2:0] b_dout;
    logic [1:0] b_level;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int qa[$];
    int qb[$];
    int rx_b[$];

    stage_fifo_sync #(.DATA_WITH(3), .DEPTH(4), .AFULL_LVL(3)) dut_a (
        .clk(clk), .rst(rst), .req_in(a_req), .data_in(a_din),
        .ack_out(a_ack_out), .req_out(a_req_out), .data_out(a_dout),
        .ack_in(a_ack), .flush(a_flush), .level(a_level), .almost_full(a_afull)
    );

    stage_fifo_sync #(.DATA_WITH(3), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .req_in(b_req), .data_in(b_din),
        .ack_out(b_ack_out), .req_out(b_req_out), .data_out(b_dout),
        .ack_in(b_ack), .flush(b_flush), .level(b_level), .almost_full(b_afull)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic f_ack(input int sz, input int depth, input logic r, input logic fl);
        return (sz < depth) && !r && !fl;
    endfunction

    function automatic logic f_req(input int sz, input logic rq, input logic fl, input logic r);
`ifdef STAGE_FIFO_BYPASS_EN
        if (sz == 0) return rq && !fl && !r;
`endif
        return (sz != 0) && !fl;
    endfunction

    function automatic int f_data(input int sz, input int head, input int din, input logic fl, input logic r);
`ifdef STAGE_FIFO_BYPASS_EN
        if (sz == 0 && !fl && !r) return din;
`endif
        return (sz == 0) ? 0 : head;
    endfunction

    // Queue model: a read pops the head, a write appends; an empty-FIFO read
    // can only be a bypass, which consumes the incoming word directly.
    always @(posedge clk) begin : m_a
        int   sz;
        logic rd, wr;
        sz = qa.size();
        if (rst || a_flush) begin
            qa.delete();
        end else begin
            rd = f_req(sz, a_req, a_flush, rst) && a_ack;
            wr = f_ack(sz, 4, rst, a_flush) && a_req;
            if (sz == 0) begin
                if (wr && !rd) qa.push_back(int'(a_din));
            end else begin
                if (rd) void'(qa.pop_front());
                if (wr) qa.push_back(int'(a_din));
            end
        end
    end

    always @(posedge clk) begin : m_b
        int   sz;
        logic rd, wr;
        sz = qb.size();
        if (rst || b_flush) begin
            qb.delete();
        end else begin
            rd = f_req(sz, b_req, b_flush, rst) && b_ack;
            wr = f_ack(sz, 3, rst, b_flush) && b_req;
            if (sz == 0) begin
                if (wr && !rd) qb.push_back(int'(b_din));
            end else begin
                if (rd) void'(qb.pop_front());
                if (wr) qb.push_back(int'(b_din));
            end
        end
    end

    always @(negedge clk) begin : cmp
        int sa, sb;
        if (chk_en) begin
            sa = qa.size();
            sb = qb.size();
            check("a_ack_out", a_ack_out, f_ack(sa, 4, rst, a_flush));
            check("a_req_out", a_req_out, f_req(sa, a_req, a_flush, rst));
            check("a_data_out", a_dout, f_data(sa, (sa > 0) ? qa[0] : 0, int'(a_din), a_flush, rst));
            check("a_level", a_level, sa);
            check("a_almost_full", a_afull, sa >= 3);
            check("b_ack_out", b_ack_out, f_ack(sb, 3, rst, b_flush));
            check("b_req_out", b_req_out, f_req(sb, b_req, b_flush, rst));
            check("b_data_out", b_dout, f_data(sb, (sb > 0) ? qb[0] : 0, int'(b_din), b_flush, rst));
            check("b_level", b_level, sb);
            check("b_almost_full", b_afull, sb >= 2);
            if (b_req_out && b_ack && !rst) rx_b.push_back(int'(b_dout));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_afull [4] = '{0, 0, 1, 1};
        int exp_drain [3] = '{3, 4, 5};
        int exp_rx    [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

        rst = 1'b1;
        a_req = 1'b1; a_din = 3'd7; a_ack = 1'b0; a_flush = 1'b0;
        b_req = 1'b0; b_din = 3'd0; b_ack = 1'b0; b_flush = 1'b0;

        // Reset held for two edges with a word offered
        step();
        chk_en = 1'b1;
        check("rst_ack_out", a_ack_out, 0);
        check("rst_req_out", a_req_out, 0);
        check("rst_level", a_level, 0);
        check("rst_data_out", a_dout, 0);
        step();
        check("rst2_level", a_level, 0);
        rst = 1'b0; a_req = 1'b0;
        #1 check("post_rst_ack_out", a_ack_out, 1);
        step();
        check("post_rst_level", a_level, 0);

        // Fill to full with consumer stalled
        for (int v = 1; v <= 4; v++) begin
            a_req = 1'b1; a_din = 3'(v); a_ack = 1'b0;
            step();
            check("fill_level", a_level, v);
            check("fill_afull", a_afull, exp_afull[v-1]);
        end
        a_din = 3'd5;
        #1 check("full_ack_out", a_ack_out, 0);
        step();
        step();
        check("held_level", a_level, 4);
        check("held_head", a_dout, 1);

        // Read and write together at full: write refused, then both complete
        a_ack = 1'b1;
        #1 check("full_rw_req_out", a_req_out, 1);
        step();
        check("full_rw_level", a_level, 3);
        check("full_rw_head", a_dout, 2);
        step();
        check("both_level", a_level, 3);
        a_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("drain_data", a_dout, exp_drain[i]);
            step();
        end
        check("drained_level", a_level, 0);
        check("drained_req_out", a_req_out, 0);
        a_ack = 1'b0;

        // Flush with two words stored and both handshakes requested
        a_req = 1'b1; a_din = 3'd6;
        step();
        a_din = 3'd7;
        step();
        check("pre_flush_level", a_level, 2);
        a_flush = 1'b1; a_din = 3'd3; a_ack = 1'b1;
        #1 check("flush_ack_out", a_ack_out, 0);
        check("flush_req_out", a_req_out, 0);
        step();
        a_flush = 1'b0; a_req = 1'b0; a_ack = 1'b0;
        #1 check("post_flush_level", a_level, 0);
        check("post_flush_req_out", a_req_out, 0);
        check("post_flush_data", a_dout, 0);

        // Empty FIFO, word offered with consumer ready
        a_req = 1'b1; a_din = 3'd5; a_ack = 1'b1;
        #1;
`ifdef STAGE_FIFO_BYPASS_EN
        check("bypass_req_out", a_req_out, 1);
        check("bypass_data", a_dout, 5);
        step();
        a_req = 1'b0; a_ack = 1'b0;
        #1 check("bypass_level", a_level, 0);
        check("bypass_after_req", a_req_out, 0);
`else
        check("latency_req_out_now", a_req_out, 0);
        step();
        a_req = 1'b0; a_ack = 1'b0;
        #1 check("latency_req_out", a_req_out, 1);
        check("latency_data", a_dout, 5);
        check("latency_level", a_level, 1);
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
`endif

        // DEPTH=3 streaming, nine words so both pointers wrap three times
        b_ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b_req = 1'b1; b_din = 3'(i % 8);
            step();
        end
`ifdef STAGE_FIFO_BYPASS_EN
        check("stream_level", b_level, 0);
`else
        check("stream_level", b_level, 1);
`endif
        b_req = 1'b0;
        step();
        step();
        b_ack = 1'b0;
        check("stream_count", rx_b.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check("stream_word", (i < rx_b.size()) ? rx_b[i] : -1, exp_rx[i]);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
